// File: rtl/fmul_arbiter.sv
// fmul_arbiter: round-robin sharing of one fmul wrapper among NREQ
// requesters, with registered operands and a WAIT-state watchdog.
module fmul_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*32-1:0] req_a,
  input  logic [NREQ*32-1:0] req_b,
  output logic [NREQ-1:0]   req_ack,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [31:0]       rsp_data,
  output logic              timeout_err,
  output logic              fu_en,
  output logic [31:0]       fu_adata,
  output logic [31:0]       fu_bdata,
  input  logic [31:0]       fu_result,
  input  logic              fu_done,
  input  logic              fu_busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_ON = (TIMEOUT > 0);
  localparam logic [CW-1:0] LIMIT =
    WD_ON ? CW'(TIMEOUT - 1) : '0;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t          state, state_d;
  logic [PW-1:0]   ptr, ptr_d;
  logic [PW-1:0]   owner, owner_d;
  logic [CW-1:0]   cnt, cnt_d;
  logic [PW-1:0]   win, idx;
  logic            found, grant, wd_hit;
  logic [NREQ-1:0] ack_d, vld_d;
  logic [31:0]     data_d, a_d, b_d;
  logic            en_d, terr_d;

  // first requester after ptr, wrapping
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = PW'((int'(ptr) + k) % NREQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign grant  = found && !fu_busy;
  assign wd_hit = WD_ON && (cnt == LIMIT);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state       <= IDLE;
      ptr         <= PW'(NREQ - 1);
      owner       <= '0;
      cnt         <= '0;
      req_ack     <= '0;
      rsp_valid   <= '0;
      rsp_data    <= '0;
      timeout_err <= 1'b0;
      fu_en       <= 1'b0;
      fu_adata    <= '0;
      fu_bdata    <= '0;
    end else begin
      state       <= state_d;
      ptr         <= ptr_d;
      owner       <= owner_d;
      cnt         <= cnt_d;
      req_ack     <= ack_d;
      rsp_valid   <= vld_d;
      rsp_data    <= data_d;
      timeout_err <= terr_d;
      fu_en       <= en_d;
      fu_adata    <= a_d;
      fu_bdata    <= b_d;
    end
  end

  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (grant) state_d = ISSUE;
      ISSUE:   state_d = WAIT;
      WAIT:    if (fu_done || wd_hit) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    ack_d   = '0;
    vld_d   = '0;
    en_d    = 1'b0;
    terr_d  = 1'b0;
    data_d  = rsp_data;
    a_d     = fu_adata;
    b_d     = fu_bdata;
    owner_d = owner;
    ptr_d   = ptr;
    cnt_d   = cnt;
    unique case (state)
      IDLE: begin
        if (grant) begin
          ack_d[win] = 1'b1;
          en_d       = 1'b1;
          a_d        = req_a[{win, 5'd0} +: 32];
          b_d        = req_b[{win, 5'd0} +: 32];
          owner_d    = win;
        end
      end
      ISSUE: cnt_d = '0;
      WAIT: begin
        cnt_d = cnt + CW'(1);
        // a result arriving on the limit cycle beats the abort
        if (fu_done) begin
          data_d       = fu_result;
          vld_d[owner] = 1'b1;
          ptr_d        = owner;
        end else if (wd_hit) begin
          data_d       = QNAN;
          vld_d[owner] = 1'b1;
          terr_d       = 1'b1;
          ptr_d        = owner;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_fmul_arbiter.sv
// Bench for fmul_arbiter: directed and randomized ops against a
// round-robin reference model and a stub multiplier.
module tb_fmul_arbiter;
  localparam int N  = 4;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [N-1:0]  req = '0;
  logic [N*32-1:0] req_a = '0;
  logic [N*32-1:0] req_b = '0;
  logic [N-1:0]  req_ack, rsp_valid;
  logic [31:0]   rsp_data, fu_adata, fu_bdata;
  logic          timeout_err, fu_en;
  logic [31:0]   fu_result = '0;
  logic          fu_done;
  logic          fu_busy = 1'b0;
  logic          fu_force = 1'b0;
  logic          fu_auto = 1'b1;
  logic          fu_done_m = 1'b0;
  int            fu_lat = 3;
  int            cd = 0;

  int checks = 0;
  int errors = 0;
  int ptr_m = N - 1;
  logic [31:0] last_rsp = '0;

  assign fu_done = fu_done_m | fu_force;

  fmul_arbiter #(.NREQ(N), .TIMEOUT(TO)) dut (
    .clk(clk), .rstn(rstn),
    .req(req), .req_a(req_a), .req_b(req_b),
    .req_ack(req_ack), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data), .timeout_err(timeout_err),
    .fu_en(fu_en), .fu_adata(fu_adata), .fu_bdata(fu_bdata),
    .fu_result(fu_result), .fu_done(fu_done), .fu_busy(fu_busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] prod(input logic [31:0] a,
                                       input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4040_0000)
      return 32'h40C0_0000;
    return (a ^ {b[15:0], b[31:16]}) + 32'h0123_4567;
  endfunction

  // stub multiplier: done fu_lat cycles after fu_en
  always @(posedge clk) begin
    if (!rstn) begin
      fu_done_m <= 1'b0;
      cd <= 0;
    end else begin
      fu_done_m <= 1'b0;
      if (fu_en && fu_auto) begin
        fu_result <= prod(fu_adata, fu_bdata);
        if (fu_lat <= 1) fu_done_m <= 1'b1;
        else cd <= fu_lat - 1;
      end else if (cd > 0) begin
        cd <= cd - 1;
        if (cd == 1) fu_done_m <= 1'b1;
      end
    end
  end

  function automatic int pick(input logic [N-1:0] r);
    for (int k = 1; k <= N; k++)
      if (r[(ptr_m + k) % N]) return (ptr_m + k) % N;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    chk("ack_onehot0", 32'($onehot0(req_ack)), 32'd1);
    chk("rsp_onehot0", 32'($onehot0(rsp_valid)), 32'd1);
  endtask

  task automatic grant(output int w, output logic [31:0] ea,
                       output logic [31:0] eb, input bit spur);
    w  = pick(req);
    ea = req_a[w*32 +: 32];
    eb = req_b[w*32 +: 32];
    tick();
    chk("req_ack", 32'(req_ack), 32'(1 << w));
    chk("fu_en", 32'(fu_en), 32'd1);
    chk("fu_adata", fu_adata, ea);
    chk("fu_bdata", fu_bdata, eb);
    req_a[w*32 +: 32] = $urandom;
    fu_force = spur;
  endtask

  task automatic respond(input int w, input logic [31:0] ea,
                         input logic [31:0] eb, input int lat,
                         input bit to);
    logic [31:0] exp_d;
    for (int i = 0; i < lat; i++) begin
      tick();
      fu_force = 1'b0;
      chk("wait_rsp_valid", 32'(rsp_valid), 32'd0);
      chk("wait_fu_en", 32'(fu_en), 32'd0);
      chk("wait_timeout", 32'(timeout_err), 32'd0);
      chk("hold_adata", fu_adata, ea);
      chk("hold_bdata", fu_bdata, eb);
    end
    tick();
    fu_force = 1'b0;
    exp_d = to ? 32'h7FC0_0000 : prod(ea, eb);
    chk("rsp_valid", 32'(rsp_valid), 32'(1 << w));
    chk("rsp_data", rsp_data, exp_d);
    chk("timeout_err", 32'(timeout_err), 32'(to));
    last_rsp = exp_d;
    ptr_m = w;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ack"}, 32'(req_ack), 32'd0);
    chk({tag, "_vld"}, 32'(rsp_valid), 32'd0);
    chk({tag, "_data"}, rsp_data, 32'd0);
    chk({tag, "_terr"}, 32'(timeout_err), 32'd0);
    chk({tag, "_en"}, 32'(fu_en), 32'd0);
    chk({tag, "_a"}, fu_adata, 32'd0);
    chk({tag, "_b"}, fu_bdata, 32'd0);
  endtask

  initial begin
    int w;
    logic [31:0] ea, eb;

    repeat (2) tick();
    chk_zero("reset");
    #2 rstn = 1'b1;

    // single op
    req = 4'b0001;
    req_a[31:0] = 32'h4000_0000;
    req_b[31:0] = 32'h4040_0000;
    fu_lat = 5;
    grant(w, ea, eb, 1'b0);
    req = '0;
    respond(w, ea, eb, 5, 1'b0);
    chk("single_data", rsp_data, 32'h40C0_0000);

    // fairness: all requesting
    req = 4'hF;
    for (int i = 0; i < N; i++) begin
      req_a[i*32 +: 32] = $urandom;
      req_b[i*32 +: 32] = $urandom;
    end
    for (int n = 0; n < 8; n++) begin
      fu_lat = $urandom_range(1, 6);
      grant(w, ea, eb, 1'b0);
      respond(w, ea, eb, fu_lat, 1'b0);
    end
    req = '0;

    // busy hold-off
    fu_busy = 1'b1;
    req = 4'b0100;
    req_a[64 +: 32] = $urandom;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("busy_ack", 32'(req_ack), 32'd0);
      chk("busy_en", 32'(fu_en), 32'd0);
    end
    fu_busy = 1'b0;
    fu_lat = 3;
    grant(w, ea, eb, 1'b0);
    req = '0;
    respond(w, ea, eb, 3, 1'b0);

    // spurious done in IDLE, then in ISSUE
    fu_force = 1'b1;
    tick();
    fu_force = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("spur_vld", 32'(rsp_valid), 32'd0);
      chk("spur_data", rsp_data, last_rsp);
      chk("spur_terr", 32'(timeout_err), 32'd0);
    end
    req = 4'b0010;
    fu_lat = 4;
    grant(w, ea, eb, 1'b1);
    req = '0;
    respond(w, ea, eb, 4, 1'b0);

    // watchdog abort, then a normal op
    fu_auto = 1'b0;
    req = 4'b1000;
    grant(w, ea, eb, 1'b0);
    req = '0;
    respond(w, ea, eb, TO, 1'b1);
    fu_auto = 1'b1;
    req = 4'b0001;
    fu_lat = 2;
    grant(w, ea, eb, 1'b0);
    req = '0;
    respond(w, ea, eb, 2, 1'b0);

    // done exactly on the limit cycle
    req = 4'b0100;
    fu_lat = TO;
    grant(w, ea, eb, 1'b0);
    req = '0;
    respond(w, ea, eb, TO, 1'b0);

    // randomized traffic
    for (int n = 0; n < 24; n++) begin
      if (req == '0) req = N'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        req_a[i*32 +: 32] = $urandom;
        req_b[i*32 +: 32] = $urandom;
      end
      fu_lat = $urandom_range(1, 7);
      grant(w, ea, eb, 1'b0);
      req[w] = 1'b0;
      req = req | N'($urandom_range(0, 15) & $urandom_range(0, 15));
      respond(w, ea, eb, fu_lat, 1'b0);
    end
    req = '0;

    // reset during WAIT
    req = 4'b0010;
    fu_lat = 6;
    grant(w, ea, eb, 1'b0);
    req = '0;
    tick();
    tick();
    #2 rstn = 1'b0;
    #1;
    chk_zero("async_rst");
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_vld", 32'(rsp_valid), 32'd0);
    end
    #2 rstn = 1'b1;
    ptr_m = N - 1;
    req = 4'hF;
    for (int i = 0; i < N; i++) begin
      req_a[i*32 +: 32] = $urandom;
      req_b[i*32 +: 32] = $urandom;
    end
    fu_lat = 2;
    grant(w, ea, eb, 1'b0);
    chk("first_after_rst", 32'(req_ack), 32'd1);
    req = '0;
    respond(w, ea, eb, 2, 1'b0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
